// File: rtl/pipe_defs.sv
// Shared definitions for the pipeline execute stage.
// Provides ALU opcodes, condition codes, control-word bit positions,
// NZCV bit positions, the multiplier FSM state type, the link register
// number and the condition evaluator shared by the execute stage.
package pipe_defs;

    // ALU opcodes carried in the control word
    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_EOR = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_RSB = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_ADC = 4'h5;
    localparam logic [3:0] ALU_SBC = 4'h6;
    localparam logic [3:0] ALU_MUL = 4'h7;
    localparam logic [3:0] ALU_TST = 4'h8;
    localparam logic [3:0] ALU_TEQ = 4'h9;
    localparam logic [3:0] ALU_CMP = 4'hA;
    localparam logic [3:0] ALU_CMN = 4'hB;
    localparam logic [3:0] ALU_ORR = 4'hC;
    localparam logic [3:0] ALU_MOV = 4'hD;
    localparam logic [3:0] ALU_BIC = 4'hE;
    localparam logic [3:0] ALU_MVN = 4'hF;

    // Condition field codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Control word bit positions
    localparam int SIG_REG_WRITE   = 0;
    localparam int SIG_MEM_READ    = 1;
    localparam int SIG_MEM_WRITE   = 2;
    localparam int SIG_BRANCH      = 3;
    localparam int SIG_LINK        = 4;
    localparam int SIG_ALU_SRC_IMM = 5;
    localparam int SIG_SET_FLAGS   = 6;
    localparam int SIG_ALU_OP_LO   = 7;
    localparam int SIG_ALU_OP_HI   = 10;

    // NZCV bit positions within the 4-bit flag word {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] LINK_REG = 4'd14;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    function automatic logic cond_passes(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cf, v, r;
        n  = nzcv[FLAG_N];
        z  = nzcv[FLAG_Z];
        cf = nzcv[FLAG_C];
        v  = nzcv[FLAG_V];
        case (c)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = cf;
            COND_CC: r = ~cf;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = cf & ~z;
            COND_LS: r = ~cf | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // TST, TEQ, CMP and CMN occupy opcodes 8..B
    function automatic logic is_compare(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier producing the low 32 bits of a*b.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (aborts a multiply)
//   start       : sampled in IDLE; loads a/b and enters BUSY
//   a, b        : multiplicand and multiplier, sampled only on start
//   busy        : high while in BUSY
//   done        : high in the last BUSY cycle (count == MUL_CYCLES-1)
//   product     : final product, valid while done is high
module iter_multiplier
    import pipe_defs::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    mul_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   acc_step;

    // Accumulator value after the current iteration; on the final
    // iteration this is the product the top registers.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    assign busy    = (state_q == MUL_BUSY);
    assign done    = busy && (count_q == LAST);
    assign product = acc_step;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 32'd0;
                    count_d  = '0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MUL_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded on start.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage of the five-stage pipeline.
// Evaluates the condition field against the NZCV register, runs the ALU,
// address, branch and iterative-multiply operations and registers the
// results into the EX/MEM boundary.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   pc_in                      : instruction address + 4
//   dataA, dataB               : Rn / Rm operands
//   br_se, ls_se, alu_se       : branch word offset, load/store byte offset, ALU immediate
//   rd_in, signals, cond       : destination, control word, condition field
//   res_out, store_data_out    : result/address/link value, store data
//   rd_out, reg_write_out,
//   mem_read_out, mem_write_out: registered destination and control
//   br_taken_out, br_target_out: registered branch decision and target
//   flags_out                  : current NZCV {N,Z,C,V}
//   ex_stall                   : combinational hold request to upstream
//   ex_flush                   : upstream loads bubbles (equals br_taken_out)
module execute_unit
    import pipe_defs::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [31:0] br_se,
    input  logic [31:0] ls_se,
    input  logic [31:0] alu_se,
    input  logic [3:0]  rd_in,
    input  logic [10:0] signals,
    input  logic [3:0]  cond,
    output logic [31:0] res_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        br_taken_out,
    output logic [31:0] br_target_out,
    output logic [3:0]  flags_out,
    output logic        ex_stall,
    output logic        ex_flush
);

    logic [3:0]  alu_op;
    logic [31:0] op_b;
    logic        is_mem, is_branch, is_mul, cmp_op;
    logic        executes, mul_start;
    logic        mul_busy, mul_done;
    logic [31:0] mul_product;

    logic [31:0] add_x, add_y;
    logic        add_cin;
    logic [32:0] add_sum;
    logic        add_v;
    logic        alu_arith;
    logic [31:0] alu_res;

    logic [31:0] res_q, res_d;
    logic [31:0] sdata_q, sdata_d;
    logic [3:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic        bt_q, bt_d;
    logic [31:0] tgt_q, tgt_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  mul_rd_q, mul_rd_d;
    logic        mul_rw_q, mul_rw_d;
    logic        mul_sf_q, mul_sf_d;

    // Instruction classification. A taken branch in the output register
    // squashes whatever sits on the input, and nothing new is accepted
    // while a multiply is in flight (the held MUL must not restart).
    always_comb begin
        alu_op    = signals[SIG_ALU_OP_HI:SIG_ALU_OP_LO];
        op_b      = signals[SIG_ALU_SRC_IMM] ? alu_se : dataB;
        is_mem    = signals[SIG_MEM_READ] | signals[SIG_MEM_WRITE];
        is_branch = signals[SIG_BRANCH] & ~is_mem;
        is_mul    = ~is_mem & ~is_branch & (alu_op == ALU_MUL);
        cmp_op    = is_compare(alu_op);
        executes  = (signals != '0) & ~bt_q & cond_passes(cond, flags_q) & ~mul_busy;
        mul_start = executes & is_mul;
    end

    // Single shared adder; subtracts use x + ~y + 1 so the carry-out is
    // directly NOT borrow.
    always_comb begin
        add_x     = dataA;
        add_y     = op_b;
        add_cin   = 1'b0;
        alu_arith = 1'b0;
        case (alu_op)
            ALU_SUB, ALU_CMP: begin
                add_y     = ~op_b;
                add_cin   = 1'b1;
                alu_arith = 1'b1;
            end
            ALU_RSB: begin
                add_x     = op_b;
                add_y     = ~dataA;
                add_cin   = 1'b1;
                alu_arith = 1'b1;
            end
            ALU_ADD, ALU_CMN: alu_arith = 1'b1;
            ALU_ADC: begin
                add_cin   = flags_q[FLAG_C];
                alu_arith = 1'b1;
            end
            ALU_SBC: begin
                add_y     = ~op_b;
                add_cin   = flags_q[FLAG_C];
                alu_arith = 1'b1;
            end
            default: ;
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
        add_v   = (add_x[31] == add_y[31]) && (add_sum[31] != add_x[31]);

        case (alu_op)
            ALU_AND, ALU_TST: alu_res = dataA & op_b;
            ALU_EOR, ALU_TEQ: alu_res = dataA ^ op_b;
            ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC,
            ALU_SBC, ALU_CMP, ALU_CMN: alu_res = add_sum[31:0];
            ALU_ORR: alu_res = dataA | op_b;
            ALU_MOV: alu_res = op_b;
            ALU_BIC: alu_res = dataA & ~op_b;
            ALU_MVN: alu_res = ~op_b;
            default: alu_res = 32'd0;
        endcase
    end

    iter_multiplier #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (dataA),
        .b      (op_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    // Next-state for the EX/MEM register and the flag register. Anything
    // that does not execute leaves a bubble (all fields zero).
    always_comb begin
        res_d    = 32'd0;
        sdata_d  = 32'd0;
        rd_d     = 4'd0;
        rw_d     = 1'b0;
        mr_d     = 1'b0;
        mw_d     = 1'b0;
        bt_d     = 1'b0;
        tgt_d    = 32'd0;
        flags_d  = flags_q;
        mul_rd_d = mul_start ? rd_in : mul_rd_q;
        mul_rw_d = mul_start ? signals[SIG_REG_WRITE] : mul_rw_q;
        mul_sf_d = mul_start ? signals[SIG_SET_FLAGS] : mul_sf_q;

        if (mul_done) begin
            res_d = mul_product;
            rd_d  = mul_rd_q;
            rw_d  = mul_rw_q;
            if (mul_sf_q) begin
                flags_d[FLAG_N] = mul_product[31];
                flags_d[FLAG_Z] = (mul_product == 32'd0);
            end
        end else if (executes && !is_mul) begin
            if (is_mem) begin
                res_d   = dataA + ls_se;
                sdata_d = dataB;
                rd_d    = rd_in;
                rw_d    = signals[SIG_REG_WRITE] & signals[SIG_MEM_READ];
                mr_d    = signals[SIG_MEM_READ];
                mw_d    = signals[SIG_MEM_WRITE];
            end else if (is_branch) begin
                bt_d  = 1'b1;
                tgt_d = pc_in + 32'd4 + (br_se << 2);
                if (signals[SIG_LINK]) begin
                    res_d = pc_in;
                    rd_d  = LINK_REG;
                    rw_d  = 1'b1;
                end
            end else begin
                res_d = alu_res;
                rd_d  = rd_in;
                rw_d  = signals[SIG_REG_WRITE] & ~cmp_op;
                if (signals[SIG_SET_FLAGS] | cmp_op) begin
                    flags_d[FLAG_N] = alu_res[31];
                    flags_d[FLAG_Z] = (alu_res == 32'd0);
                    if (alu_arith) begin
                        flags_d[FLAG_C] = add_sum[32];
                        flags_d[FLAG_V] = add_v;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q    <= 32'd0;
            sdata_q  <= 32'd0;
            rd_q     <= 4'd0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            bt_q     <= 1'b0;
            tgt_q    <= 32'd0;
            flags_q  <= 4'd0;
            mul_rd_q <= 4'd0;
            mul_rw_q <= 1'b0;
            mul_sf_q <= 1'b0;
        end else begin
            res_q    <= res_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            bt_q     <= bt_d;
            tgt_q    <= tgt_d;
            flags_q  <= flags_d;
            mul_rd_q <= mul_rd_d;
            mul_rw_q <= mul_rw_d;
            mul_sf_q <= mul_sf_d;
        end
    end

    // Stall from the cycle a MUL is accepted until the last iteration,
    // so upstream advances on the same edge that registers the product.
    assign ex_stall = mul_start | (mul_busy & ~mul_done);
    assign ex_flush = bt_q;

    assign res_out        = res_q;
    assign store_data_out = sdata_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = rw_q;
    assign mem_read_out   = mr_q;
    assign mem_write_out  = mw_q;
    assign br_taken_out   = bt_q;
    assign br_target_out  = tgt_q;
    assign flags_out      = flags_q;

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

    localparam int MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, dataA, dataB, br_se, ls_se, alu_se;
    logic [3:0]  rd_in, cond;
    logic [10:0] signals;
    logic [31:0] res_out, store_data_out, br_target_out;
    logic [3:0]  rd_out, flags_out;
    logic        reg_write_out, mem_read_out, mem_write_out, br_taken_out;
    logic        ex_stall, ex_flush;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_flags;
    logic       m_flush;

    typedef struct {
        logic [31:0] pc, a, b, br, ls, imm;
        logic [3:0]  rd;
        logic [10:0] sig;
        logic [3:0]  cond;
    } instr_t;

    typedef struct {
        logic [31:0] res, tgt, sdata;
        logic [3:0]  rd, flags;
        logic        rw, mr, mw, bt, stall;
    } exp_t;

    execute_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .dataA(dataA), .dataB(dataB),
        .br_se(br_se), .ls_se(ls_se), .alu_se(alu_se), .rd_in(rd_in),
        .signals(signals), .cond(cond), .res_out(res_out),
        .store_data_out(store_data_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .br_taken_out(br_taken_out),
        .br_target_out(br_target_out), .flags_out(flags_out),
        .ex_stall(ex_stall), .ex_flush(ex_flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input instr_t in, input logic [3:0] fl, input logic flush);
        exp_t e;
        logic [3:0] op;
        logic [31:0] ob, r;
        longint ua, ub, sa, sb, sr;
        logic cy, c_new, arith, is_cmp, upd;
        e.res = 0; e.tgt = 0; e.sdata = 0; e.rd = 0; e.flags = fl;
        e.rw = 0; e.mr = 0; e.mw = 0; e.bt = 0; e.stall = 0;
        if (in.sig == 11'd0 || flush || !cond_ok(in.cond, fl)) return e;
        if (in.sig[1] || in.sig[2]) begin
            e.res = in.a + in.ls;
            e.sdata = in.b;
            e.rd = in.rd;
            e.rw = in.sig[0] && in.sig[1];
            e.mr = in.sig[1];
            e.mw = in.sig[2];
            return e;
        end
        if (in.sig[3]) begin
            e.bt = 1;
            e.tgt = in.pc + 32'd4 + in.br * 32'd4;
            if (in.sig[4]) begin
                e.res = in.pc; e.rd = 4'd14; e.rw = 1;
            end
            return e;
        end
        op = in.sig[10:7];
        ob = in.sig[5] ? in.imm : in.b;
        ua = {32'd0, in.a};  ub = {32'd0, ob};
        sa = $signed(in.a);  sb = $signed(ob);
        cy = fl[1];
        arith = 0; c_new = 0; sr = 0; r = 0;
        case (op)
            4'h0, 4'h8: r = in.a & ob;
            4'h1, 4'h9: r = in.a ^ ob;
            4'h2, 4'hA: begin r = in.a - ob; c_new = ua >= ub; sr = sa - sb; arith = 1; end
            4'h3: begin r = ob - in.a; c_new = ub >= ua; sr = sb - sa; arith = 1; end
            4'h4, 4'hB: begin r = in.a + ob; c_new = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; arith = 1; end
            4'h5: begin
                r = in.a + ob + {31'd0, cy};
                c_new = (ua + ub + (cy ? 1 : 0)) > 64'hFFFF_FFFF;
                sr = sa + sb + (cy ? 1 : 0); arith = 1;
            end
            4'h6: begin
                r = in.a - ob - {31'd0, !cy};
                c_new = ua >= ub + (cy ? 0 : 1);
                sr = sa - sb - (cy ? 0 : 1); arith = 1;
            end
            4'h7: begin r = in.a * ob; e.stall = 1; end
            4'hC: r = in.a | ob;
            4'hD: r = ob;
            4'hE: r = in.a & ~ob;
            default: r = ~ob;
        endcase
        is_cmp = (op >= 4'h8) && (op <= 4'hB);
        e.res = r;
        e.rd = in.rd;
        e.rw = in.sig[0] && !is_cmp;
        upd = in.sig[6] || is_cmp;
        if (upd) begin
            e.flags[3] = r[31];
            e.flags[2] = (r == 0);
            if (arith) begin
                e.flags[1] = c_new;
                e.flags[0] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        end
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic instr_t blank();
        instr_t in;
        in.pc = 0; in.a = 0; in.b = 0; in.br = 0; in.ls = 0; in.imm = 0;
        in.rd = 0; in.sig = 0; in.cond = 4'hE;
        return in;
    endfunction

    function automatic instr_t mk_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic sf, input logic [3:0] c);
        instr_t in = blank();
        in.a = a; in.b = b; in.rd = 4'd3; in.cond = c;
        in.sig = {op, sf, 5'b00000, 1'b1};
        return in;
    endfunction

    function automatic instr_t mk_br(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] off,
                                     input logic link);
        instr_t in = blank();
        in.pc = pc; in.br = off; in.cond = c;
        in.sig = {4'h0, 1'b0, 1'b0, link, 1'b1, 3'b000};
        return in;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t in = blank();
        int kind;
        logic [3:0] op;
        in.pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        in.a = rand_word(); in.b = rand_word(); in.imm = rand_word();
        in.br = 32'($signed(12'($urandom)));
        in.ls = 32'($signed(12'($urandom)));
        in.rd = 4'($urandom);
        in.cond = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
        kind = $urandom_range(0, 9);
        op = 4'($urandom);
        if (op == 4'h7 && $urandom_range(0, 1) == 0) op = 4'h4;
        case (kind)
            5: in.sig = 11'b000_0000_0011;
            6: in.sig = 11'b000_0000_0100;
            7: in.sig = {4'h0, 2'b00, 1'($urandom), 1'b1, 3'b000};
            8: in.sig = 11'd0;
            default: in.sig = {op, 1'($urandom), 1'($urandom), 4'b0000, 1'($urandom)};
        endcase
        return in;
    endfunction

    task automatic drive(input instr_t in);
        pc_in = in.pc; dataA = in.a; dataB = in.b; br_se = in.br;
        ls_se = in.ls; alu_se = in.imm; rd_in = in.rd; signals = in.sig; cond = in.cond;
    endtask

    // Present one instruction (holding it through any stall) and check the
    // registered result against the model.
    task automatic issue(input instr_t in);
        exp_t e;
        int n;
        logic bubbles_ok;
        e = model(in, m_flags, m_flush);
        drive(in);
        #1;
        check_eq("stall_at_issue", {31'd0, ex_stall}, {31'd0, e.stall});
        if (e.stall) begin
            n = 0;
            bubbles_ok = 1'b1;
            while (ex_stall && n < 100) begin
                @(posedge clk); #1;
                n++;
                if (reg_write_out || br_taken_out || mem_read_out || mem_write_out) bubbles_ok = 1'b0;
            end
            check_eq("mul_stall_cycles", n, MUL_CYCLES);
            check_eq("bubble_during_stall", {31'd0, bubbles_ok}, 32'd1);
        end
        @(posedge clk); #1;
        check_eq("res_out", res_out, e.res);
        check_eq("rd_out", {28'd0, rd_out}, {28'd0, e.rd});
        check_eq("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
        check_eq("mem_read_out", {31'd0, mem_read_out}, {31'd0, e.mr});
        check_eq("mem_write_out", {31'd0, mem_write_out}, {31'd0, e.mw});
        check_eq("store_data_out", store_data_out, e.sdata);
        check_eq("br_taken_out", {31'd0, br_taken_out}, {31'd0, e.bt});
        check_eq("br_target_out", br_target_out, e.tgt);
        check_eq("ex_flush", {31'd0, ex_flush}, {31'd0, e.bt});
        check_eq("flags_out", {28'd0, flags_out}, {28'd0, e.flags});
        m_flags = e.flags;
        m_flush = e.bt;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {res_out | store_data_out | br_target_out}, 32'd0);
        check_eq({tag, "_ctl"}, {22'd0, rd_out, reg_write_out, mem_read_out, mem_write_out,
                                 br_taken_out, ex_flush, ex_stall}, 32'd0);
        check_eq({tag, "_flags"}, {28'd0, flags_out}, 32'd0);
    endtask

    initial begin
        instr_t in;
        int rw_seen;
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t in;
        int rw_seen;
        reset = 1'b1;
        drive(blank());
        m_flags = 4'd0;
        m_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // CMP 5,5 then BEQ back-to-back, then a squashed branch
        issue(mk_alu(4'hA, 32'd5, 32'd5, 1'b0, 4'hE));
        check_eq("cmp_flags", {28'd0, flags_out}, 32'h6);
        check_eq("cmp_no_write", {31'd0, reg_write_out}, 32'd0);
        issue(mk_br(4'h0, 32'h100, 32'd3, 1'b0));
        check_eq("beq_taken", {31'd0, br_taken_out}, 32'd1);
        check_eq("beq_target", br_target_out, 32'h110);
        check_eq("beq_flush", {31'd0, ex_flush}, 32'd1);
        issue(mk_br(4'hE, 32'h400, 32'd8, 1'b1));
        check_eq("squash_taken", {31'd0, br_taken_out}, 32'd0);
        check_eq("squash_flush", {31'd0, ex_flush}, 32'd0);

        // ADDS signed overflow
        issue(mk_alu(4'h4, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'hE));
        check_eq("adds_res", res_out, 32'h8000_0000);
        check_eq("adds_flags", {28'd0, flags_out}, 32'h9);

        // Failed condition: SUBNE with Z=1
        issue(mk_alu(4'hA, 32'd0, 32'd0, 1'b0, 4'hE));
        issue(mk_alu(4'h2, 32'd9, 32'd4, 1'b1, 4'h1));
        check_eq("subne_bubble", {31'd0, reg_write_out}, 32'd0);
        check_eq("subne_flags", {28'd0, flags_out}, 32'h6);

        // MUL 7 x 0xFFFFFFFF with flags
        issue(mk_alu(4'h7, 32'd7, 32'hFFFF_FFFF, 1'b1, 4'hE));
        check_eq("mul_res", res_out, 32'hFFFF_FFF9);
        check_eq("mul_n", {31'd0, flags_out[3]}, 32'd1);

        // MUL failing its condition does not stall
        issue(mk_alu(4'h7, 32'd3, 32'd3, 1'b0, 4'hF));

        // LDR and BL
        in = blank();
        in.a = 32'h1000; in.ls = 32'hFFFF_FFFC; in.rd = 4'd2; in.sig = 11'b000_0000_0011;
        issue(in);
        check_eq("ldr_addr", res_out, 32'h0FFC);
        check_eq("ldr_read", {31'd0, mem_read_out}, 32'd1);
        issue(mk_br(4'hE, 32'h204, 32'd16, 1'b1));
        check_eq("bl_rd", {28'd0, rd_out}, 32'd14);
        check_eq("bl_res", res_out, 32'h204);
        issue(blank());

        // Reset while a multiply is in flight
        drive(mk_alu(4'h7, 32'd5, 32'd6, 1'b1, 4'hE));
        repeat (5) @(posedge clk);
        #1;
        drive(blank());
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("busy_reset");
        reset = 1'b0;
        m_flags = 4'd0;
        m_flush = 1'b0;
        rw_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (reg_write_out || ex_stall) rw_seen++;
        end
        check_eq("abort_no_writeback", rw_seen, 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            issue(rand_instr());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
